// File: rtl/if_prefetch_stage_pkg.sv
// if_prefetch_stage_pkg: exception codes, bus widths and decode entry layout shared across the core
package if_prefetch_stage_pkg;
  localparam logic [4:0] EX_ADEL = 5'h04;
  localparam logic [4:0] EX_TLBL = 5'h02;
  localparam int FS_TO_DS_BUS_WD = 71;
  typedef struct packed {
    logic        tlb_refill;
    logic        ex;
    logic [4:0]  exccode;
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_entry_t;
endpackage

// File: rtl/if_prefetch_stage_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count and single-cycle flush
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign dout = mem[rp];
  // storage write; a full queue may push only when it pops, so the slot at wp is free
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  // pointers and occupancy, emptied by reset or flush
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/if_prefetch_stage.sv
// if_prefetch_stage: prefetching fetch stage with instruction queue; FETCH_TLB_EN enables TLB-mapped fetch
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IQ_DEPTH        = 4,
  parameter logic [31:0] RESET_PC        = 32'hbfc00000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_cancel,
  input  logic [31:0]                new_pc,
  input  logic                       br_valid,
  input  logic [31:0]                br_target,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [31:0]                inst_sram_addr,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addrok,
  input  logic                       inst_sram_dataok,
  input  logic [31:0]                inst_sram_rdata,
  output logic [18:0]                s0_vpn2,
  output logic                       s0_odd_page,
  output logic [7:0]                 s0_asid,
  input  logic                       s0_found,
  input  logic                       s0_v,
  input  logic [19:0]                s0_pfn,
  input  logic [7:0]                 entryhi_asid
);
  localparam int PCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int ICW = $clog2(IQ_DEPTH + 1);
  logic [31:0] fpc, pend_pc;
  logic fault, redirect, accept, drop, deliver, fault_push, iq_pop;
  logic misaligned, tlb_fault, tlb_refill, legal;
  logic [PCW-1:0] pend_cnt, discard;
  logic [ICW-1:0] iq_cnt;
  fs_entry_t iq_in;
`ifdef FETCH_TLB_EN
  logic mapped;
  assign mapped         = fpc[31:30] != 2'b10;
  assign s0_vpn2        = fpc[31:13];
  assign s0_odd_page    = fpc[12];
  assign s0_asid        = entryhi_asid;
  assign tlb_fault      = mapped && !(s0_found && s0_v);
  assign tlb_refill     = mapped && !s0_found;
  assign inst_sram_addr = mapped ? {s0_pfn, fpc[11:0]} : fpc;
`else
  logic unused_tlb;
  assign unused_tlb     = ^{s0_found, s0_v, s0_pfn, entryhi_asid};
  assign s0_vpn2        = '0;
  assign s0_odd_page    = 1'b0;
  assign s0_asid        = '0;
  assign tlb_fault      = 1'b0;
  assign tlb_refill     = 1'b0;
  assign inst_sram_addr = fpc;
`endif
  assign redirect        = ws_cancel || br_valid;
  assign misaligned      = |fpc[1:0];
  assign legal           = !misaligned && !tlb_fault;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_req   = !reset && !redirect && !fault && legal && 32'(pend_cnt) < MAX_OUTSTANDING &&
                           32'(pend_cnt) + 32'(iq_cnt) < IQ_DEPTH;
  assign accept          = inst_sram_req && inst_sram_addrok;
  assign drop            = inst_sram_dataok && discard != '0;
  assign deliver         = inst_sram_dataok && discard == '0 && !redirect;
  assign fs_to_ds_valid  = iq_cnt != '0;
  assign iq_pop          = fs_to_ds_valid && ds_allowin;
  // a fault is queued only once everything fetched before it has drained, keeping program order
  assign fault_push      = !legal && !fault && !redirect && pend_cnt == '0 && discard == '0 &&
                           (32'(iq_cnt) < IQ_DEPTH || iq_pop);
  // queue entry: returned instruction, or an exception marker at the faulting fetch address
  always_comb begin
    iq_in            = '0;
    iq_in.pc         = fault_push ? fpc : pend_pc;
    iq_in.inst       = fault_push ? 32'h0 : inst_sram_rdata;
    iq_in.ex         = fault_push;
    iq_in.exccode    = fault_push ? (misaligned ? EX_ADEL : EX_TLBL) : 5'h0;
    iq_in.tlb_refill = fault_push && !misaligned && tlb_refill;
  end
  // fetch pointer, fault latch and count of stale responses still owed by the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc     <= RESET_PC;
      fault   <= 1'b0;
      discard <= '0;
    end else begin
      fpc     <= ws_cancel ? new_pc : br_valid ? br_target : accept ? fpc + 32'd4 : fpc;
      fault   <= redirect ? 1'b0 : fault || fault_push;
      discard <= redirect ? pend_cnt - PCW'(inst_sram_dataok) : discard - PCW'(drop);
    end
  end
  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pend (
    .clk(clk), .reset(reset), .push(accept), .pop(inst_sram_dataok), .flush(1'b0),
    .din(fpc), .dout(pend_pc), .count(pend_cnt)
  );
  fetch_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IQ_DEPTH)) u_iq (
    .clk(clk), .reset(reset), .push(deliver || fault_push), .pop(iq_pop), .flush(redirect),
    .din(iq_in), .dout(fs_to_ds_bus), .count(iq_cnt)
  );
endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb_if_prefetch_stage: randomized bus/decode stimulus checked against an expected-PC-stream model
module tb_if_prefetch_stage;
  localparam int MAXO = 2;
  localparam int IQD = 4;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  logic clk, reset, ws_cancel, br_valid, ds_allowin, fs_to_ds_valid;
  logic [31:0] new_pc, br_target;
  logic [70:0] fs_to_ds_bus;
  logic inst_sram_req, inst_sram_wr, inst_sram_addrok, inst_sram_dataok;
  logic [1:0] inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0] inst_sram_wstrb;
  logic [18:0] s0_vpn2;
  logic s0_odd_page, s0_found, s0_v;
  logic [7:0] s0_asid, entryhi_asid;
  logic [19:0] s0_pfn;
  typedef struct {logic [31:0] a; int t;} rsp_t;
  rsp_t rq[$];
  logic [70:0] got[$];
  int gcyc[$];
  int checks, errors, cyc, viol, req_seen, addr_pct, data_pct, lat_extra;
  logic took, hold_req;
  logic [70:0] taken;
  logic [31:0] hold_addr;

  if_prefetch_stage #(.MAX_OUTSTANDING(MAXO), .IQ_DEPTH(IQD), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ws_cancel(ws_cancel), .new_pc(new_pc), .br_valid(br_valid),
    .br_target(br_target), .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus), .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addrok(inst_sram_addrok),
    .inst_sram_dataok(inst_sram_dataok), .inst_sram_rdata(inst_sram_rdata), .s0_vpn2(s0_vpn2),
    .s0_odd_page(s0_odd_page), .s0_asid(s0_asid), .s0_found(s0_found), .s0_v(s0_v),
    .s0_pfn(s0_pfn), .entryhi_asid(entryhi_asid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] code(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc0de1234;
  endfunction
  function automatic logic [70:0] norm(input logic [31:0] pc);
    return {7'h0, code(pc), pc};
  endfunction
  function automatic logic [70:0] fault_e(input logic refill, input logic [4:0] exc, input logic [31:0] pc);
    return {refill, 1'b1, exc, 32'h0, pc};
  endfunction

  // one bus cycle: drive the sram-like slave, sample outputs 1ns later, then advance past the edge
  task automatic step();
    rsp_t r;
    inst_sram_addrok = $urandom_range(99) < addr_pct;
    inst_sram_dataok = rq.size() > 0 && rq[0].t <= cyc && $urandom_range(99) < data_pct;
    inst_sram_rdata = inst_sram_dataok ? code(rq[0].a) : $urandom;
    #1;
    took = fs_to_ds_valid && ds_allowin;
    taken = fs_to_ds_bus;
    if (inst_sram_req && (inst_sram_wr || inst_sram_size != 2'd2 || inst_sram_wstrb != 4'h0 || inst_sram_wdata != 32'h0)) viol++;
    if (hold_req && !ws_cancel && !br_valid && (!inst_sram_req || inst_sram_addr != hold_addr)) viol++;
    if (inst_sram_dataok) void'(rq.pop_front());
    if (inst_sram_req && inst_sram_addrok) begin
      r.a = inst_sram_addr;
      r.t = cyc + 1 + int'($urandom_range(lat_extra));
      rq.push_back(r);
    end
    if (rq.size() > MAXO) viol++;
    req_seen += int'(inst_sram_req);
    hold_req = inst_sram_req && !inst_sram_addrok;
    hold_addr = inst_sram_addr;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      int c = cyc;
      step();
      if (took) begin
        got.push_back(taken);
        gcyc.push_back(c);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ws_cancel = 1'b0;
    br_valid = 1'b0;
    ds_allowin = 1'b0;
    inst_sram_addrok = 1'b0;
    inst_sram_dataok = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rq.delete();
    got.delete();
    gcyc.delete();
    hold_req = 1'b0;
    cyc = 0;
    viol = 0;
  endtask

  task automatic zero_wait();
    addr_pct = 100;
    data_pct = 100;
    lat_extra = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ds_allowin = 1'b1;
    ws_cancel = 1'($urandom);
    br_valid = 1'($urandom);
    new_pc = $urandom;
    br_target = $urandom;
    inst_sram_addrok = 1'b1;
    inst_sram_dataok = 1'b1;
    inst_sram_rdata = $urandom;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", fs_to_ds_valid); end
    checks++;
    if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", inst_sram_req); end
    reset = 1'b0;
    ws_cancel = 1'b0;
    br_valid = 1'b0;
    inst_sram_dataok = 1'b0;
    #1;
    checks++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== RST_PC) begin
      errors++; $display("FAIL reset_first_fetch got req=%b addr=%h exp req=1 addr=%h", inst_sram_req, inst_sram_addr, RST_PC);
    end
    checks++;
    if ({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata} !== {1'b0, 2'd2, 4'h0, 32'h0}) begin
      errors++; $display("FAIL reset_req_fields got wr=%b size=%0d wstrb=%h wdata=%h", inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    zero_wait();
    ds_allowin = 1'b1;
    run(8);
    checks++;
    if (got.size() !== 6) begin errors++; $display("FAIL zw_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== norm(RST_PC + 32'(4 * i)) || gcyc[i] !== 2 + i) begin
        errors++; $display("FAIL zw_entry%0d got=%h@%0d exp=%h@%0d", i, got[i], gcyc[i], norm(RST_PC + 32'(4 * i)), 2 + i);
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL zw_protocol got=%0d violations exp=0", viol); end
  endtask

  task automatic test_stall();
    do_reset();
    zero_wait();
    ds_allowin = 1'b0;
    run(10);
    checks++;
    if (fs_to_ds_valid !== 1'b1 || inst_sram_req !== 1'b0 || rq.size() !== 0) begin
      errors++; $display("FAIL stall_hold got valid=%b req=%b pending=%0d exp 1 0 0", fs_to_ds_valid, inst_sram_req, rq.size());
    end
    addr_pct = 0;
    ds_allowin = 1'b1;
    run(8);
    checks++;
    if (got.size() !== IQD) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got.size(), IQD); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== norm(RST_PC + 32'(4 * i))) begin
        errors++; $display("FAIL stall_entry%0d got=%h exp=%h", i, got[i], norm(RST_PC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_cancel();
    do_reset();
    addr_pct = 100;
    data_pct = 0;
    lat_extra = 0;
    ds_allowin = 1'b1;
    for (int i = 0; i < 10 && rq.size() < 2; i++) run(1);
    checks++;
    if (rq.size() !== 2) begin errors++; $display("FAIL cancel_pending got=%0d exp=2", rq.size()); end
    ws_cancel = 1'b1;
    new_pc = 32'hbfc00380;
    run(1);
    ws_cancel = 1'b0;
    data_pct = 100;
    got.delete();
    run(12);
    checks++;
    if (got.size() < 4) begin errors++; $display("FAIL cancel_progress got=%0d exp>=4", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== norm(32'hbfc00380 + 32'(4 * i))) begin
        errors++; $display("FAIL cancel_entry%0d got=%h exp=%h", i, got[i], norm(32'hbfc00380 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_same_cycle();
    int nb;
    do_reset();
    zero_wait();
    ds_allowin = 1'b1;
    run(5);
    ws_cancel = 1'b1;
    new_pc = 32'hbfc00380;
    br_valid = 1'b1;
    br_target = 32'h80001000;
    run(1);
    ws_cancel = 1'b0;
    br_valid = 1'b0;
    nb = got.size();
    run(10);
    checks++;
    if (nb < 1 || got.size() < nb + 3) begin errors++; $display("FAIL both_progress got old=%0d total=%0d exp old>=1 new>=3", nb, got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      logic [70:0] e = i < nb ? norm(RST_PC + 32'(4 * i)) : norm(32'hbfc00380 + 32'(4 * (i - nb)));
      checks++;
      if (got[i] !== e) begin errors++; $display("FAIL both_entry%0d got=%h exp=%h", i, got[i], e); end
    end
  endtask

  task automatic test_misaligned();
    int nb, rs;
    do_reset();
    addr_pct = 70;
    data_pct = 60;
    lat_extra = 2;
    for (int i = 0; i < 20; i++) begin
      ds_allowin = $urandom_range(4) != 0;
      run(1);
    end
    br_valid = 1'b1;
    br_target = 32'hbfc00102;
    ds_allowin = 1'b1;
    run(1);
    br_valid = 1'b0;
    nb = got.size();
    data_pct = 100;
    rs = req_seen;
    run(40);
    for (int i = 0; i < nb; i++) begin
      checks++;
      if (got[i] !== norm(RST_PC + 32'(4 * i))) begin
        errors++; $display("FAIL adel_old%0d got=%h exp=%h", i, got[i], norm(RST_PC + 32'(4 * i)));
      end
    end
    checks++;
    if (got.size() !== nb + 1) begin errors++; $display("FAIL adel_count got=%0d exp=%0d", got.size() - nb, 1); end
    else begin
      checks++;
      if (got[nb] !== fault_e(1'b0, 5'h04, 32'hbfc00102)) begin
        errors++; $display("FAIL adel_entry got=%h exp=%h", got[nb], fault_e(1'b0, 5'h04, 32'hbfc00102));
      end
    end
    checks++;
    if (req_seen !== rs) begin errors++; $display("FAIL adel_noreq got=%0d requests exp=0", req_seen - rs); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL adel_protocol got=%0d violations exp=0", viol); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    addr_pct = 100;
    data_pct = 0;
    lat_extra = 0;
    ds_allowin = 1'b1;
    for (int i = 0; i < 10 && rq.size() < 2; i++) run(1);
    checks++;
    if (rq.size() !== 2) begin errors++; $display("FAIL rstmid_pending got=%0d exp=2", rq.size()); end
    do_reset();
    zero_wait();
    ds_allowin = 1'b1;
    run(8);
    checks++;
    if (got.size() !== 6) begin errors++; $display("FAIL rstmid_count got=%0d exp=6", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== norm(RST_PC + 32'(4 * i))) begin
        errors++; $display("FAIL rstmid_entry%0d got=%h exp=%h", i, got[i], norm(RST_PC + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    logic [70:0] e;
    logic blocked;
    int n, r;
    do_reset();
    addr_pct = 60;
    data_pct = 60;
    lat_extra = 3;
    exp_pc = RST_PC;
    blocked = 1'b0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      ds_allowin = $urandom_range(3) != 0;
      ws_cancel = 1'b0;
      br_valid = 1'b0;
      if ($urandom_range(99) < 3) begin
        tgt = RST_PC + 32'($urandom_range(255)) * 32'd4 + ($urandom_range(3) == 0 ? 32'($urandom_range(3, 1)) : 32'd0);
        r = int'($urandom_range(2));
        ws_cancel = r != 0;
        br_valid = r != 1;
        new_pc = tgt;
        br_target = r == 0 ? tgt : RST_PC + 32'($urandom_range(255)) * 32'd4;
      end
      step();
      if (took) begin
        n++;
        checks++;
        if (blocked) begin
          errors++; $display("FAIL rnd_after_fault got=%h exp=no entry", taken);
        end else begin
          e = exp_pc[1:0] != 2'b00 ? fault_e(1'b0, 5'h04, exp_pc) : norm(exp_pc);
          if (taken !== e) begin errors++; $display("FAIL rnd_entry%0d got=%h exp=%h", n, taken, e); end
          if (exp_pc[1:0] != 2'b00) blocked = 1'b1;
          else exp_pc = exp_pc + 32'd4;
        end
      end
      if (ws_cancel || br_valid) begin
        exp_pc = ws_cancel ? new_pc : br_target;
        blocked = 1'b0;
      end
    end
    ws_cancel = 1'b0;
    br_valid = 1'b0;
    checks++;
    if (n < 200) begin errors++; $display("FAIL rnd_progress got=%0d exp>=200", n); end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL rnd_protocol got=%0d violations exp=0", viol); end
  endtask

`ifdef FETCH_TLB_EN
  task automatic test_tlb();
    int rs;
    do_reset();
    zero_wait();
    ds_allowin = 1'b1;
    s0_found = 1'b0;
    ws_cancel = 1'b1;
    new_pc = 32'h00400000;
    run(1);
    ws_cancel = 1'b0;
    got.delete();
    rs = req_seen;
    run(10);
    checks++;
    if (s0_vpn2 !== 19'h00200) begin errors++; $display("FAIL tlb_vpn2 got=%h exp=%h", s0_vpn2, 19'h00200); end
    checks++;
    if (got.size() !== 1) begin errors++; $display("FAIL tlb_count got=%0d exp=1", got.size()); end
    else begin
      checks++;
      if (got[0] !== fault_e(1'b1, 5'h02, 32'h00400000)) begin
        errors++; $display("FAIL tlb_entry got=%h exp=%h", got[0], fault_e(1'b1, 5'h02, 32'h00400000));
      end
    end
    checks++;
    if (req_seen !== rs) begin errors++; $display("FAIL tlb_noreq got=%0d requests exp=0", req_seen - rs); end
    s0_found = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    viol = 0;
    req_seen = 0;
    hold_req = 1'b0;
    hold_addr = 32'h0;
    addr_pct = 100;
    data_pct = 100;
    lat_extra = 0;
    new_pc = 32'h0;
    br_target = 32'h0;
    inst_sram_rdata = 32'h0;
    s0_found = 1'b1;
    s0_v = 1'b1;
    s0_pfn = 20'h0;
    entryhi_asid = 8'h05;
    test_reset();
    test_zero_wait();
    test_stall();
    test_cancel();
    test_same_cycle();
    test_misaligned();
    test_reset_mid();
    test_random();
`ifdef FETCH_TLB_EN
    test_tlb();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
